// File: rtl/boxcar_decimator.sv
// boxcar_decimator: rate reducer placed after the boxcar moving-average filter.
// Takes one output sample per M = 2^DECIM_LOG2 accepted input samples and
// presents it as a single-cycle o_ce pulse with a registered o_data.
//
// Build option: define BOXCAR_DECIM_AVERAGE_EN to switch from pick mode (emit
// the last sample of each group) to integrate-and-dump mode (emit the group
// mean, floor-rounded by an arithmetic shift). Ports and timing are the same
// in both builds.
module boxcar_decimator #(
  parameter int DATA_WIDTH = 8,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_ce,
  input  logic [DATA_WIDTH-1:0]                         i_data,
  input  logic                                          i_sync,
  output logic [DATA_WIDTH-1:0]                         o_data,
  output logic                                          o_ce,
  output logic [((DECIM_LOG2 > 0) ? DECIM_LOG2 : 1)-1:0] o_phase
);

  localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int AW = DATA_WIDTH + DECIM_LOG2;

  generate
    if (DECIM_LOG2 == 0) begin : g_pass
      // M = 1: every sample is its own group, so the block is a one-cycle
      // registered copy and i_sync has nothing to realign.
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  ce_q, ce_d;

      // Next-state for the pass-through register.
      always_comb begin
        data_d = i_data;
        ce_d   = i_ce;
      end

      // Pass-through register with synchronous reset.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          data_q <= {DATA_WIDTH{1'b0}};
          ce_q   <= 1'b0;
        end else begin
          data_q <= data_d;
          ce_q   <= ce_d;
        end
      end

      assign o_data  = data_q;
      assign o_ce    = ce_q;
      assign o_phase = {PW{1'b0}};
    end else begin : g_decim
      localparam logic [PW-1:0] PHASE_ONE  = PW'(1'b1);
      localparam logic [PW-1:0] PHASE_LAST = {PW{1'b1}};

      logic [PW-1:0]         phase_q, phase_d;
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  ce_q, ce_d;
      logic                  last_s;

`ifdef BOXCAR_DECIM_AVERAGE_EN
      // AW bits hold the sum of M full-scale samples without overflow, and
      // the shifted mean always fits back into DATA_WIDTH.
      logic signed [AW-1:0] acc_q, acc_d;
      logic signed [AW-1:0] sum_s, mean_s;
`endif

      assign last_s = (phase_q == PHASE_LAST);

      // Group sequencing: sync realigns, an accepted sample advances the
      // phase, and the sample at phase M-1 (without sync) fires the output.
      always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        ce_d    = 1'b0;
`ifdef BOXCAR_DECIM_AVERAGE_EN
        acc_d   = acc_q;
        sum_s   = acc_q + AW'($signed(i_data));
        mean_s  = sum_s >>> DECIM_LOG2;
`endif
        if (i_sync) begin
          // Sync wins over a pending group end: no output on this cycle.
          if (i_ce) begin
            phase_d = PHASE_ONE;
`ifdef BOXCAR_DECIM_AVERAGE_EN
            acc_d   = AW'($signed(i_data));
`endif
          end else begin
            phase_d = {PW{1'b0}};
`ifdef BOXCAR_DECIM_AVERAGE_EN
            acc_d   = {AW{1'b0}};
`endif
          end
        end else if (i_ce) begin
          // Natural wrap of the PW-bit counter gives modulo-M counting.
          phase_d = phase_q + PHASE_ONE;
          if (last_s) begin
            ce_d   = 1'b1;
`ifdef BOXCAR_DECIM_AVERAGE_EN
            data_d = mean_s[DATA_WIDTH-1:0];
            acc_d  = {AW{1'b0}};
`else
            data_d = i_data;
`endif
          end else begin
`ifdef BOXCAR_DECIM_AVERAGE_EN
            acc_d  = sum_s;
`else
            data_d = data_q;
`endif
          end
        end else begin
          phase_d = phase_q;
        end
      end

      // State and output registers; reset drops any partial group.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          phase_q <= {PW{1'b0}};
          data_q  <= {DATA_WIDTH{1'b0}};
          ce_q    <= 1'b0;
`ifdef BOXCAR_DECIM_AVERAGE_EN
          acc_q   <= {AW{1'b0}};
`endif
        end else begin
          phase_q <= phase_d;
          data_q  <= data_d;
          ce_q    <= ce_d;
`ifdef BOXCAR_DECIM_AVERAGE_EN
          acc_q   <= acc_d;
`endif
        end
      end

      assign o_data  = data_q;
      assign o_ce    = ce_q;
      assign o_phase = phase_q;
    end
  endgenerate

endmodule

// File: tb/tb_boxcar_decimator.sv
// Scoreboard bench for boxcar_decimator (DATA_WIDTH=8, DECIM_LOG2=2).
// Expected outputs follow the build: pick mode by default, group mean when
// BOXCAR_DECIM_AVERAGE_EN is defined.
module tb_boxcar_decimator;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_ce;
  logic signed [7:0] i_data;
  logic              i_sync;
  logic signed [7:0] o_data;
  logic              o_ce;
  logic [1:0]        o_phase;

  boxcar_decimator #(.DATA_WIDTH(8), .DECIM_LOG2(2)) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .i_ce   (i_ce),
    .i_data (i_data),
    .i_sync (i_sync),
    .o_data (o_data),
    .o_ce   (o_ce),
    .o_phase(o_phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int at;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every o_ce pulse must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    if (o_ce === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_o_ce: got o_ce=1 o_data=%0d, expected no output (cycle %0d)", o_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("o_data", int'(o_data), e.val);
        check("o_ce_cycle", cyc, e.at);
      end
    end
  end

  // One input cycle; optionally checks o_phase before driving.
  task automatic step(input int d, input logic ce, input logic sync, input int exp_phase);
    @(negedge clk);
    if (exp_phase >= 0) check("o_phase", int'(o_phase), exp_phase);
    i_data = 8'(d);
    i_ce   = ce;
    i_sync = sync;
  endtask

  // Called right after the step that completes a group: output due after the next edge.
  task automatic expect_out(input int v);
    exp_t e;
    e.val = v;
    e.at  = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int exp_phase);
    for (int k = 0; k < n; k++) step(0, 1'b0, 1'b0, exp_phase);
  endtask

  // Feeds four samples as one full group starting at phase 0.
  task automatic group4(input int a, input int b, input int c, input int d, input int exp);
    step(a, 1'b1, 1'b0, 0);
    step(b, 1'b1, 1'b0, 1);
    step(c, 1'b1, 1'b0, 2);
    step(d, 1'b1, 1'b0, 3);
    expect_out(exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b1;
    i_ce    = 1'b0;
    i_data  = 8'sd0;
    i_sync  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_o_data", int'(o_data), 0);
    check("reset_o_ce", int'(o_ce), 0);
    check("reset_o_phase", int'(o_phase), 0);
    i_reset = 1'b0;

    // 1: back-to-back samples 1..8
    for (int i = 1; i <= 8; i++) begin
      step(i, 1'b1, 1'b0, (i - 1) % 4);
`ifdef BOXCAR_DECIM_AVERAGE_EN
      if (i == 4) expect_out(2);
      if (i == 8) expect_out(6);
`else
      if (i % 4 == 0) expect_out(i);
`endif
    end
    idle(3, 0);

    // 2: sparse i_ce, phase holds between samples
    for (int v = 1; v <= 4; v++) begin
      step(v, 1'b1, 1'b0, v - 1);
`ifdef BOXCAR_DECIM_AVERAGE_EN
      if (v == 4) expect_out(2);
`else
      if (v == 4) expect_out(4);
`endif
      idle(2, v % 4);
    end
    idle(1, 0);

    // 3: sync with a sample mid-group
    step(1, 1'b1, 1'b0, 0);
    step(2, 1'b1, 1'b0, 1);
    step(3, 1'b1, 1'b1, 2);
    step(4, 1'b1, 1'b0, 1);
    step(5, 1'b1, 1'b0, 2);
    step(6, 1'b1, 1'b0, 3);
`ifdef BOXCAR_DECIM_AVERAGE_EN
    expect_out(4);
`else
    expect_out(6);
`endif
    idle(2, 0);
    // sync at phase M-1 with a sample: no output, phase 1
    step(1, 1'b1, 1'b0, 0);
    step(2, 1'b1, 1'b0, 1);
    step(3, 1'b1, 1'b0, 2);
    step(9, 1'b1, 1'b1, 3);
    idle(1, 1);
    // sync without a sample: phase back to 0
    step(0, 1'b0, 1'b1, 1);
    idle(1, 0);
    group4(10, 20, 30, 40,
`ifdef BOXCAR_DECIM_AVERAGE_EN
           25
`else
           40
`endif
          );
    idle(2, 0);
    check("hold_o_data", int'(o_data),
`ifdef BOXCAR_DECIM_AVERAGE_EN
          25
`else
          40
`endif
         );

    // 4: reset mid-group, with a sample offered during reset
    step(1, 1'b1, 1'b0, 0);
    step(2, 1'b1, 1'b0, 1);
    @(negedge clk);
    i_reset = 1'b1;
    i_ce    = 1'b1;
    i_data  = 8'sd9;
    @(negedge clk);
    check("midreset_o_data", int'(o_data), 0);
    check("midreset_o_ce", int'(o_ce), 0);
    check("midreset_o_phase", int'(o_phase), 0);
    i_reset = 1'b0;
    i_ce    = 1'b0;
    step(3, 1'b1, 1'b0, 0);
    step(4, 1'b1, 1'b0, 1);
    check("postreset_o_data", int'(o_data), 0);
    step(5, 1'b1, 1'b0, 2);
    step(6, 1'b1, 1'b0, 3);
    check("postreset_o_data2", int'(o_data), 0);
`ifdef BOXCAR_DECIM_AVERAGE_EN
    expect_out(4);
`else
    expect_out(6);
`endif
    idle(2, 0);

    // 5 and 6: signed values and extremes
`ifdef BOXCAR_DECIM_AVERAGE_EN
    group4(12, -1, -2, -3, 1);
    group4(-4, 5, 6, 7, 3);
    group4(1, 2, 3, 4, 2);
    group4(-1, -2, -3, -4, -3);
    group4(127, 127, 127, 127, 127);
    group4(-128, -128, -128, -128, -128);
`else
    group4(12, -1, -2, -3, -3);
    group4(-4, 5, 6, 7, 7);
    group4(1, 2, 3, 4, 4);
    group4(-1, -2, -3, -4, -4);
    group4(127, 127, 127, 127, 127);
    group4(-128, -128, -128, -128, -128);
`endif
    idle(4, 0);

    check("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boxcar_decimator.md
Name: boxcar_decimator

Overview:
- Downstream stage of the boxcar (moving-average) filter.
- Consumes the filter's o_data/o_ce sample stream and reduces the rate by M = 2^DECIM_LOG2.
- Emits one registered output sample per M accepted input samples, as a single-cycle o_ce pulse.
- Its output feeds the next lower-rate stage of the DSP chain.

Parameters:
- DATA_WIDTH, 8, signed sample width on input and output.
- DECIM_LOG2, 2, log2 of the decimation factor M. Range 0..8. A value of 0 gives a registered pass-through.

Ports:
- i_clk  input  1  system clock, rising edge; the only clock.
- i_reset  input  1  synchronous, active-high reset.
- i_ce  input  1  input sample valid / clock enable. Connects to the upstream filter's o_ce.
- i_data  input  DATA_WIDTH  signed input sample. Connects to the upstream filter's o_data.
- i_sync  input  1  group realign. The current cycle starts a new decimation group.
- o_data  output  DATA_WIDTH  signed decimated sample.
- o_ce  output  1  single-cycle pulse; o_data is new this cycle.
- o_phase  output  DECIM_LOG2 (min 1)  current group position counter, for debug and alignment.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Everything updates on the rising edge of i_clk.
- Reset (i_reset=1 at an edge):
  - o_data=0, o_ce=0, o_phase=0, accumulator=0.
  - Reset has priority over every other input.
  - Reset mid-group discards the partial group; no output is produced for it.
- Phase counter:
  - Counts accepted samples (i_ce=1) modulo M.
  - Holds while i_ce=0.
  - Wraps from M-1 to 0.
- Output event:
  - Occurs when i_ce=1, phase==M-1 and i_sync=0.
  - On the next edge: o_ce=1 for exactly one cycle, and o_data takes the new value.
  - Latency is 1 cycle from the accepted sample that completes the group.
- Pick mode (default): o_data = i_data of the last sample in the group, i.e. the sample at phase M-1.
- Hold behaviour:
  - o_data holds its value between events.
  - o_ce=0 in every cycle without an event, including when i_ce stays high.
- i_sync:
  - i_sync=1 with i_ce=1: this sample is treated as phase 0. phase<=1, and the accumulator is loaded with the sample. No output occurs, even if the old phase was M-1 (sync wins).
  - i_sync=1 with i_ce=0: phase<=0, accumulator<=0, no output.
  - With M=1, i_sync has no effect on output: every accepted sample is emitted.
- DECIM_LOG2=0: o_data<=i_data and o_ce<=i_ce every cycle (1-cycle registered copy).
- Upstream constraints: no backpressure, since the upstream filter cannot stall. i_ce may be high on consecutive cycles or sparse, and both are legal.
- Width rules:
  - Internal accumulator is signed, DATA_WIDTH+DECIM_LOG2 bits.
  - It cannot overflow for any M inputs.

Optional Feature:
- Macro: BOXCAR_DECIM_AVERAGE_EN.
- Defined (integrate-and-dump):
  - The accumulator sums all M accepted samples of a group.
  - At the output event, o_data = (acc + i_data) >>> DECIM_LOG2. This is an arithmetic shift, rounding toward minus infinity.
  - The accumulator is then cleared (dumped) on the same edge.
  - The result always fits in DATA_WIDTH, so no saturation logic is needed.
  - Latency is unchanged at 1 cycle.
- Undefined:
  - Pick mode as described above.
  - The accumulator and adder are not synthesised.
  - Port list and timing are identical in both builds.

Test Plan:
1. Pick mode, M=4, i_ce=1 every cycle, inputs 1..8 -> o_ce pulses on the cycle after sample 4 and after sample 8. o_data=4, then 8. o_ce is high for exactly 2 cycles total; o_phase sequence is 0,1,2,3,0,1,2,3.
2. Sparse i_ce: pulse every 3rd cycle with 1,2,3,4 -> one o_ce, 1 cycle after the edge that accepts 4, with o_data=4. o_phase holds between pulses.
3. Sync mid-group: feed 1,2, then 3 with i_sync=1, then 4,5,6 -> the single output has o_data=6, 1 cycle after 6 is accepted. No output is produced around sample 3.
4. Reset mid-group: feed 1,2, assert i_reset for 1 cycle, then feed 3,4,5,6 -> o_data=0 and o_ce=0 during and after reset. The first output is o_data=6.
5. Negative values, pick mode: 12,-1,-2,-3 -> o_data=-3 (0xFD). Then -4,5,6,7 -> o_data=7.
6. BOXCAR_DECIM_AVERAGE_EN defined, M=4:
   - 1,2,3,4 -> o_data=2 (10>>>2).
   - -1,-2,-3,-4 -> o_data=-3 (-10>>>2).
   - 127×4 -> 127.
   - -128×4 -> -128.
